// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing the HACK memory bus between CPU (A) and DMA (B).
// Define MEM_ARB_LOCK_EN to add a_lock/b_lock for bounded back-to-back ownership.
module mem_bus_arbiter #(
    parameter logic [15:0] RAM_TOP  = 16'd3839,
    parameter logic [15:0] IO_BASE  = 16'd4096,
    parameter logic [15:0] IO_COUNT = 16'd16,
    parameter int          LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MEM_ARB_LOCK_EN
    input  logic        a_lock,
    input  logic        b_lock,
`endif
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_done,
    output logic        a_err,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_done,
    output logic        b_err,
    output logic [15:0] b_rdata,
    output logic [15:0] mem_address,
    output logic        mem_load,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [16:0] IO_END = {1'b0, IO_BASE} + {1'b0, IO_COUNT};

    state_t      stateNow, stateNext;
    logic [15:0] capAddr, capWdata;
    logic        capWe, capB, lastB;
    logic        grantAny, grantB;
    logic [15:0] aRdata, bRdata;
    logic        errReg;
    logic        legal;

    assign legal = (capAddr <= RAM_TOP) ||
                   ((capAddr >= IO_BASE) && ({1'b0, capAddr} < IO_END));

`ifdef MEM_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_MAX);
    logic [LCW-1:0] lockCnt;
    logic           lastLocked, winnerLock;

    assign lastLocked = lastB ? (b_lock && b_req) : (a_lock && a_req);
    assign winnerLock = grantB ? b_lock : a_lock;

    // Count consecutive grants taken under lock by the current owner; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockCnt <= '0;
        end else if (grantAny) begin
            if (!winnerLock)
                lockCnt <= '0;
            else if (grantB == lastB)
                lockCnt <= (lockCnt == LOCK_LIM) ? lockCnt : lockCnt + LCW'(1);
            else
                lockCnt <= LCW'(1);
        end else if (!(lastB ? b_lock : a_lock)) begin
            lockCnt <= '0;
        end
    end
`endif

    always_comb begin
        stateNext = stateNow;
        grantAny  = 1'b0;
        grantB    = 1'b0;
        case (stateNow)
            IDLE: begin
                if (a_req || b_req) begin
                    grantAny  = 1'b1;
                    grantB    = (a_req && b_req) ? !lastB : b_req;
`ifdef MEM_ARB_LOCK_EN
                    if (lastLocked && (lockCnt < LOCK_LIM))
                        grantB = lastB;
`endif
                    stateNext = ACCESS;
                end
            end
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateNow <= IDLE;
            capAddr  <= '0;
            capWdata <= '0;
            capWe    <= 1'b0;
            capB     <= 1'b0;
            lastB    <= 1'b1;
            aRdata   <= '0;
            bRdata   <= '0;
            errReg   <= 1'b0;
        end else begin
            stateNow <= stateNext;
            if (grantAny) begin
                capAddr  <= grantB ? b_addr  : a_addr;
                capWdata <= grantB ? b_wdata : a_wdata;
                capWe    <= grantB ? b_we    : a_we;
                capB     <= grantB;
                lastB    <= grantB;
            end
            // Read data is sampled during the access, so a write returns the pre-write value.
            if (stateNow == ACCESS) begin
                errReg <= !legal;
                if (capB) bRdata <= legal ? mem_out : 16'h0000;
                else      aRdata <= legal ? mem_out : 16'h0000;
            end
        end
    end

    // Bus address/data come straight from the capture registers so they hold between accesses.
    assign mem_address = capAddr;
    assign mem_wdata   = capWdata;
    assign mem_load    = (stateNow == ACCESS) && capWe && legal;

    assign a_gnt   = (stateNow == ACCESS) && !capB;
    assign b_gnt   = (stateNow == ACCESS) &&  capB;
    assign a_done  = (stateNow == RESP)   && !capB;
    assign b_done  = (stateNow == RESP)   &&  capB;
    assign a_err   = a_done && errReg;
    assign b_err   = b_done && errReg;
    assign a_rdata = aRdata;
    assign b_rdata = bRdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: drivers queue expected grants/responses, a monitor checks them.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] mem_address, mem_wdata, mem_out;
    logic        mem_load;
`ifdef MEM_ARB_LOCK_EN
    logic        a_lock, b_lock;
`endif

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } resp_t;

    resp_t expA[$];
    resp_t expB[$];
    bit    gntQ[$];
    int    nChecks = 0;
    int    nFails  = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MEM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_load(mem_load), .mem_wdata(mem_wdata),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every grant and done must match the next queued expectation for that port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_gnt || b_gnt) begin
                chk("gnt_exclusive", {31'd0, a_gnt && b_gnt}, 32'd0);
                if (gntQ.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
                else chk("gnt_port", {31'd0, b_gnt}, {31'd0, gntQ.pop_front()});
            end
            if (a_done) begin
                if (expA.size() == 0) chk("a_done_unexpected", 32'd1, 32'd0);
                else chk("a_resp", {15'd0, a_err, a_rdata}, {15'd0, expA.pop_front()});
            end
            if (b_done) begin
                if (expB.size() == 0) chk("b_done_unexpected", 32'd1, 32'd0);
                else chk("b_resp", {15'd0, b_err, b_rdata}, {15'd0, expB.pop_front()});
            end
        end
    end

    task automatic setPort(input bit pb, input bit req, input bit we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (pb) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; end
        else    begin a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; end
    endtask

    task automatic checkIdleOutputs(input string nm);
        chk({nm, "_ctrl"}, {24'd0, a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_load, 1'b0}, 32'd0);
        chk({nm, "_rdata"}, {a_rdata, b_rdata}, 32'd0);
        chk({nm, "_bus"}, {mem_address, mem_wdata}, 32'd0);
    endtask

    // Single transaction: issued right after a posedge with the FSM in IDLE.
    task automatic doReq(input bit pb, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] mout,
                         input bit expErr, input logic [15:0] expRd, input bit expLoad);
        int n;
        mem_out = mout;
        gntQ.push_back(pb);
        if (pb) expB.push_back({expErr, expRd});
        else    expA.push_back({expErr, expRd});
        setPort(pb, 1'b1, we, addr, wdata);
        n = 0;
        do begin @(negedge clk); n++; end while (!(pb ? b_gnt : a_gnt) && n < 20);
        chk("gnt_latency", n, 2);
        chk("mem_address", {16'd0, mem_address}, {16'd0, addr});
        chk("mem_load_access", {31'd0, mem_load}, {31'd0, expLoad});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
        @(posedge clk); #1;
        setPort(pb, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, pb ? b_done : a_done}, 32'd1);
        chk("mem_load_resp", {31'd0, mem_load}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Both ports request continuously until nG grants have been observed.
    task automatic runBoth(input int nG);
        int cnt, guard;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'd2;
        cnt = 0; guard = 0;
        while (cnt < nG && guard < 200) begin
            @(negedge clk);
            guard++;
            if (a_gnt || b_gnt) cnt++;
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        chk("both_grant_count", cnt, nG);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        mem_out = 16'h0000;
`ifdef MEM_ARB_LOCK_EN
        a_lock = 1'b0; b_lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("post_reset");
        @(posedge clk); #1;

        // A read of RAM, A write to an IO slot, then two unmapped B accesses.
        doReq(1'b0, 1'b0, 16'd5,    16'h0000, 16'h1234, 1'b0, 16'h1234, 1'b0);
        doReq(1'b0, 1'b1, 16'd4100, 16'hBEEF, 16'h0042, 1'b0, 16'h0042, 1'b1);
        doReq(1'b1, 1'b1, 16'd3840, 16'h5555, 16'h7777, 1'b1, 16'h0000, 1'b0);
        doReq(1'b1, 1'b0, 16'd4112, 16'h0000, 16'h7777, 1'b1, 16'h0000, 1'b0);
        doReq(1'b0, 1'b0, 16'd3839, 16'h0000, 16'h0F0F, 1'b0, 16'h0F0F, 1'b0);
        doReq(1'b1, 1'b0, 16'd4111, 16'h0000, 16'hA5A5, 1'b0, 16'hA5A5, 1'b0);

        // Reset during the access cycle of a write: load must drop at once, no done follows.
        begin
            int n;
            mem_out = 16'h0000;
            gntQ.push_back(1'b0);
            setPort(1'b0, 1'b1, 1'b1, 16'd10, 16'h1111);
            n = 0;
            do begin @(negedge clk); n++; end while (!a_gnt && n < 20);
            chk("rst_gnt_seen", {31'd0, a_gnt}, 32'd1);
            chk("rst_load_before", {31'd0, mem_load}, 32'd1);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_load_dropped", {31'd0, mem_load}, 32'd0);
            setPort(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            checkIdleOutputs("after_mid_reset");
            @(posedge clk); #1;
        end

        // Continuous contention straight after reset: A,B,A,B.
        mem_out = 16'h00AA;
        for (int i = 0; i < 2; i++) begin
            gntQ.push_back(1'b0); gntQ.push_back(1'b1);
            expA.push_back({1'b0, 16'h00AA});
            expB.push_back({1'b0, 16'h00AA});
        end
        runBoth(4);

`ifdef MEM_ARB_LOCK_EN
        // A locked: 8 A grants, then B, then A again.
        a_lock = 1'b1;
        mem_out = 16'h0055;
        for (int i = 0; i < 8; i++) begin
            gntQ.push_back(1'b0);
            expA.push_back({1'b0, 16'h0055});
        end
        gntQ.push_back(1'b1); expB.push_back({1'b0, 16'h0055});
        gntQ.push_back(1'b0); expA.push_back({1'b0, 16'h0055});
        runBoth(10);
        a_lock = 1'b0;
`endif

        repeat (4) @(posedge clk);
        chk("queues_drained", expA.size() + expB.size() + gntQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
